wb_mmio_timer: RTL and testbench
================================

WB_MMIO_TIMER -- requirements
Module: wb_mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0000_CAA0, word-aligned base of the 4-register window.
REQ-002 SHALL have wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have wb_rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle and write-enable.
REQ-005 SHALL have wbs_sel_i  input  4  byte enables; byte n writes bits [8n+7:8n].
REQ-006 SHALL have wbs_adr_i, wbs_dat_i  input  32 each  byte address and write data.
REQ-007 SHALL have wbs_ack_o  output  1  and wbs_dat_o  output  32  as the registered acknowledge and read data.
REQ-008 SHALL have tmr_out  output  1  timer compare output pin.
REQ-009 SHALL have irq_o  output  1  level interrupt.

Function
REQ-010 Register map: CTRL at BASE+0x0, CMP at +0x4, CNT at +0x8, STAT at +0xC; hit = adr[31:4]==BASE_ADR[31:4].
REQ-011 CTRL: [2:0] source (0 off, 1 every clk, 2 clk/16, 3 clk/256, 4-7 off); [4:3] mode (0 free-run wrap at 2^32, 1 reset-on-match, 2 one-shot, 3 treated as 0); [6:5] output (0 hold, 1 toggle, 2 set, 3 clear on match); [7] irq enable; [31:8] read 0.
REQ-012 Ack: wbs_ack_o <= stb & cyc & hit-or-miss & ~wbs_ack_o, one-cycle pulse one clock after request; held strobe yields ack every second cycle.
REQ-013 Unmapped address inside cycle SHALL still ack; read data 0; write ignored.
REQ-014 Reads return the register value sampled in the request cycle; wbs_dat_o is 0 when ack is low.
REQ-015 Tick: 8-bit prescaler free-runs while source!=0; tick = 1 each clk (src 1), prescaler[3:0]==15 (src 2), prescaler==255 (src 3); prescaler clears on any CTRL write.
REQ-016 On tick with CNT!=CMP: CNT <= CNT+1 (mod 2^32).
REQ-017 On tick with CNT==CMP (match): STAT[0] <= 1; output action per CTRL[6:5] applied same edge; mode 0 CNT+1, mode 1 CNT <= 0, mode 2 CNT held and CTRL[2:0] <= 0.
REQ-018 CMP=0 with mode 1: match every tick, period 1 tick.
REQ-019 Bus write to CNT in same cycle as tick: bus value wins, no match evaluated that cycle.
REQ-020 STAT[0] write-1-to-clear; match set in same cycle as clear SHALL win (flag stays 1).
REQ-021 tmr_out registered, changes only on match or reset.

Reset
REQ-022 On wb_rst_i: CTRL, CMP, CNT, STAT, prescaler = 0; wbs_ack_o = 0; wbs_dat_o = 0; tmr_out = 0; irq_o = 0.
REQ-023 Reset mid-transaction SHALL drop ack and discard the pending write.

Configuration
REQ-024 Macro TIMER_IRQ_EN defined: irq_o = STAT[0] & CTRL[7], registered (1-cycle after flag).
REQ-025 TIMER_IRQ_EN undefined: irq_o tied 0, CTRL[7] not stored and reads 0.

Verification
REQ-026 Write CMP=0x10, CTRL=0x29 (toggle, mode 1, src 1) -> tmr_out toggles every 17 clocks, CNT cycles 0..0x10.
REQ-027 CMP=3, CTRL=0x52 (set, mode 2, src 2) -> tmr_out rises after 64 clocks, CNT holds 3, CTRL reads 0x50.
REQ-028 Read BASE+0x20 and write 0xFFFF_FFFF there -> ack in 1 clock, data 0, no register changes.
REQ-029 Write CNT=0xFFFF_FFFF, CMP=5, CTRL=0x01 -> CNT wraps to 0 then match at 5, STAT=1; STAT write 1 coincident with next match leaves STAT=1.
REQ-030 With TIMER_IRQ_EN, CTRL=0xA9, CMP=2 -> irq_o high 1 clock after first match, low 1 clock after STAT W1C; without macro irq_o stays 0.
REQ-031 Assert wb_rst_i during an acked CMP write -> all outputs 0 next clock, CMP reads 0.

Source files
------------

// File: rtl/wb_mmio_timer.sv
// ============================================================================
// Module   : wb_mmio_timer
// Brief    : Wishbone-mapped 32-bit timer with prescaler, compare match, output
//            pin action and optional interrupt (enabled by macro TIMER_IRQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mmio_timer #(
  parameter logic [31:0] BASE_ADR = 32'h0000_CAA0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        tmr_out,
  output logic        irq_o
);

  localparam logic [1:0] c_reg_ctrl = 2'd0;
  localparam logic [1:0] c_reg_cmp  = 2'd1;
  localparam logic [1:0] c_reg_cnt  = 2'd2;
  localparam logic [1:0] c_reg_stat = 2'd3;

`ifdef TIMER_IRQ_EN
  localparam logic [7:0] c_ctrl_mask = 8'hFF;
`else
  localparam logic [7:0] c_ctrl_mask = 8'h7F;
`endif

  logic        r_ack;
  logic [31:0] r_dat;
  logic [7:0]  r_ctrl;
  logic [31:0] r_cmp;
  logic [31:0] r_cnt;
  logic        r_stat;
  logic [7:0]  r_pre;
  logic        r_tmr;

  logic        w_req;
  logic        w_hit;
  logic        w_wr;
  logic [1:0]  w_idx;
  logic [31:0] w_mask;
  logic        w_wr_ctrl;
  logic        w_wr_cmp;
  logic        w_wr_cnt;
  logic        w_clr_stat;
  logic [2:0]  w_src;
  logic [1:0]  w_mode;
  logic [1:0]  w_outm;
  logic        w_tick;
  logic        w_match;
  logic [31:0] w_rd;
  logic        w_unused_ok;

  assign w_req  = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_hit  = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_wr   = w_req & wbs_we_i & w_hit;
  assign w_idx  = wbs_adr_i[3:2];
  assign w_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign w_wr_ctrl  = w_wr & (w_idx == c_reg_ctrl);
  assign w_wr_cmp   = w_wr & (w_idx == c_reg_cmp);
  assign w_wr_cnt   = w_wr & (w_idx == c_reg_cnt);
  assign w_clr_stat = w_wr & (w_idx == c_reg_stat) & wbs_sel_i[0] & wbs_dat_i[0];

  assign w_src  = r_ctrl[2:0];
  assign w_mode = r_ctrl[4:3];
  assign w_outm = r_ctrl[6:5];

  assign w_unused_ok = ^wbs_adr_i[1:0];

  always_comb begin
    w_tick = 1'b0;
    case (w_src)
      3'd1:    w_tick = 1'b1;
      3'd2:    w_tick = (r_pre[3:0] == 4'hF);
      3'd3:    w_tick = (r_pre == 8'hFF);
      default: w_tick = 1'b0;
    endcase
  end

  // A bus write to CNT pre-empts any tick, so no match is evaluated then.
  assign w_match = w_tick & ~w_wr_cnt & (r_cnt == r_cmp);

  always_comb begin
    w_rd = 32'd0;
    if (w_hit) begin
      case (w_idx)
        c_reg_ctrl: w_rd = {24'd0, r_ctrl};
        c_reg_cmp:  w_rd = r_cmp;
        c_reg_cnt:  w_rd = r_cnt;
        c_reg_stat: w_rd = {31'd0, r_stat};
        default:    w_rd = 32'd0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~wbs_we_i) ? w_rd : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pre <= 8'd0;
      r_cmp <= 32'd0;
    end else begin
      if (w_wr_ctrl)
        r_pre <= 8'd0;
      else if (w_src != 3'd0)
        r_pre <= r_pre + 8'd1;
      if (w_wr_cmp)
        r_cmp <= (r_cmp & ~w_mask) | (wbs_dat_i & w_mask);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= 32'd0;
    end else if (w_wr_cnt) begin
      r_cnt <= (r_cnt & ~w_mask) | (wbs_dat_i & w_mask);
    end else if (w_tick) begin
      if (w_match && w_mode == 2'd1)
        r_cnt <= 32'd0;
      else if (!(w_match && w_mode == 2'd2))
        r_cnt <= r_cnt + 32'd1;
    end
  end

  // A one-shot match disarms the source; an explicit CTRL write overrides it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ctrl <= 8'd0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= ((r_ctrl & ~w_mask[7:0]) | (wbs_dat_i[7:0] & w_mask[7:0])) & c_ctrl_mask;
    end else if (w_match && w_mode == 2'd2) begin
      r_ctrl[2:0] <= 3'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_stat <= 1'b0;
      r_tmr  <= 1'b0;
    end else begin
      if (w_match)
        r_stat <= 1'b1;
      else if (w_clr_stat)
        r_stat <= 1'b0;
      if (w_match) begin
        case (w_outm)
          2'd1:    r_tmr <= ~r_tmr;
          2'd2:    r_tmr <= 1'b1;
          2'd3:    r_tmr <= 1'b0;
          default: r_tmr <= r_tmr;
        endcase
      end
    end
  end

`ifdef TIMER_IRQ_EN
  logic r_irq;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      r_irq <= 1'b0;
    else
      r_irq <= r_stat & r_ctrl[7];
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign tmr_out   = r_tmr;

endmodule

`default_nettype wire

// File: tb/tb_wb_mmio_timer.sv
// ============================================================================
// Module   : tb_wb_mmio_timer
// Brief    : Directed self-checking bench for wb_mmio_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mmio_timer;

  localparam logic [31:0] c_base = 32'h0000_CAA0;
  localparam logic [31:0] c_ctrl = c_base + 32'h0;
  localparam logic [31:0] c_cmp  = c_base + 32'h4;
  localparam logic [31:0] c_cnt  = c_base + 32'h8;
  localparam logic [31:0] c_stat = c_base + 32'hC;
  localparam logic [31:0] c_miss = c_base + 32'h20;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        tmr;
  logic        irq;

  int n_checks;
  int n_fail;

  wb_mmio_timer #(.BASE_ADR(c_base)) u_dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .tmr_out   (tmr),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Request is sampled on the first edge; one idle edge follows so ack is low again.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0;
    rd  = 32'd0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 4);
    if (!ack) chk_eq("ack_timeout", 32'd0, 32'd1);
    rd  = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    step(1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int          lat;
    wb_xfer(1'b1, a, d, s, rd, lat);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    int lat;
    wb_xfer(1'b0, a, 32'd0, 4'hF, rd, lat);
  endtask

  initial begin
    logic [31:0] v;
    int          lat;
    n_checks = 0;
    n_fail   = 0;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    chk_eq("rst_ack", {31'd0, ack}, 32'd0);
    chk_eq("rst_dat", rdat, 32'd0);
    chk_eq("rst_tmr", {31'd0, tmr}, 32'd0);
    chk_eq("rst_irq", {31'd0, irq}, 32'd0);
    wb_read(c_ctrl, v); chk_eq("rst_ctrl", v, 32'd0);
    wb_read(c_cmp,  v); chk_eq("rst_cmp",  v, 32'd0);
    wb_read(c_cnt,  v); chk_eq("rst_cnt",  v, 32'd0);
    wb_read(c_stat, v); chk_eq("rst_stat", v, 32'd0);

    // Toggle, reset-on-match, every clock: period of 17.
    wb_write(c_cmp, 32'h10, 4'hF);
    wb_write(c_ctrl, 32'h29, 4'hF);
    wb_read(c_cnt, v);  chk_eq("t26_cnt1", v, 32'd1);
    step(13);           chk_eq("t26_tmr_pre", {31'd0, tmr}, 32'd0);
    step(1);            chk_eq("t26_tmr_rise", {31'd0, tmr}, 32'd1);
    wb_read(c_cnt, v);  chk_eq("t26_cnt_wrap", v, 32'd0);
    step(14);           chk_eq("t26_tmr_hold", {31'd0, tmr}, 32'd1);
    step(1);            chk_eq("t26_tmr_fall", {31'd0, tmr}, 32'd0);
    wb_read(c_stat, v); chk_eq("t26_stat", v, 32'd1);

    // One-shot, set output, clk/16.
    do_reset();
    wb_write(c_cmp, 32'd3, 4'hF);
    wb_write(c_ctrl, 32'h52, 4'hF);
    step(62);           chk_eq("t27_tmr_pre", {31'd0, tmr}, 32'd0);
    step(1);            chk_eq("t27_tmr_set", {31'd0, tmr}, 32'd1);
    wb_read(c_cnt, v);  chk_eq("t27_cnt", v, 32'd3);
    wb_read(c_ctrl, v); chk_eq("t27_ctrl", v, 32'h50);
    wb_read(c_cnt, v);  chk_eq("t27_cnt_hold", v, 32'd3);

    // Unmapped address and byte enables.
    do_reset();
    wb_write(c_cmp, 32'h1234_5678, 4'hF);
    wb_xfer(1'b0, c_miss, 32'd0, 4'hF, v, lat);
    chk_eq("t28_rd_lat", lat, 32'd1);
    chk_eq("t28_rd_dat", v, 32'd0);
    wb_xfer(1'b1, c_miss, 32'hFFFF_FFFF, 4'hF, v, lat);
    chk_eq("t28_wr_lat", lat, 32'd1);
    wb_read(c_ctrl, v); chk_eq("t28_ctrl", v, 32'd0);
    wb_read(c_cmp,  v); chk_eq("t28_cmp",  v, 32'h1234_5678);
    wb_read(c_cnt,  v); chk_eq("t28_cnt",  v, 32'd0);
    wb_read(c_stat, v); chk_eq("t28_stat", v, 32'd0);
    wb_write(c_cmp, 32'hAABB_CCDD, 4'b0101);
    wb_read(c_cmp,  v); chk_eq("t28_sel", v, 32'h12BB_56DD);

    // Wrap at 2^32, match, W1C, and set-beats-clear.
    do_reset();
    wb_write(c_cnt, 32'hFFFF_FFFF, 4'hF);
    wb_write(c_cmp, 32'd5, 4'hF);
    wb_read(c_cnt, v);  chk_eq("t29_cnt_max", v, 32'hFFFF_FFFF);
    wb_write(c_ctrl, 32'h01, 4'hF);
    wb_read(c_cnt, v);  chk_eq("t29_cnt_wrap", v, 32'd0);
    wb_read(c_stat, v); chk_eq("t29_stat_pre", v, 32'd0);
    step(2);
    wb_read(c_stat, v); chk_eq("t29_stat_set", v, 32'd1);
    wb_write(c_stat, 32'd1, 4'hF);
    wb_read(c_stat, v); chk_eq("t29_stat_clr", v, 32'd0);
    wb_write(c_cnt, 32'd4, 4'hF);
    wb_write(c_stat, 32'd1, 4'hF);
    wb_read(c_stat, v); chk_eq("t29_set_wins", v, 32'd1);
    wb_read(c_cnt, v);  chk_eq("t29_cnt_run", v, 32'd9);

    // Interrupt timing (or its absence).
    do_reset();
    wb_write(c_cmp, 32'd2, 4'hF);
    wb_write(c_ctrl, 32'hA9, 4'hF);
    step(2);            chk_eq("t30_irq_pre", {31'd0, irq}, 32'd0);
    step(1);
`ifdef TIMER_IRQ_EN
    chk_eq("t30_irq_rise", {31'd0, irq}, 32'd1);
`else
    chk_eq("t30_irq_tied", {31'd0, irq}, 32'd0);
`endif
    wb_write(c_ctrl, 32'h80, 4'hF);
    wb_read(c_ctrl, v);
`ifdef TIMER_IRQ_EN
    chk_eq("t30_ctrl", v, 32'h80);
    chk_eq("t30_irq_hold", {31'd0, irq}, 32'd1);
`else
    chk_eq("t30_ctrl", v, 32'h00);
    chk_eq("t30_irq_hold", {31'd0, irq}, 32'd0);
`endif
    wb_write(c_stat, 32'd1, 4'hF);
    chk_eq("t30_irq_fall", {31'd0, irq}, 32'd0);

    // Reset in the middle of an acknowledged CMP write.
    do_reset();
    wb_write(c_ctrl, 32'h41, 4'hF);
    chk_eq("t31_tmr_set", {31'd0, tmr}, 32'd1);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = c_cmp; wdat = 32'h55; sel = 4'hF;
    step(1);            chk_eq("t31_ack", {31'd0, ack}, 32'd1);
    rst = 1'b1;
    step(1);
    chk_eq("t31_ack0", {31'd0, ack}, 32'd0);
    chk_eq("t31_dat0", rdat, 32'd0);
    chk_eq("t31_tmr0", {31'd0, tmr}, 32'd0);
    chk_eq("t31_irq0", {31'd0, irq}, 32'd0);
    rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    step(1);
    wb_read(c_cmp, v);  chk_eq("t31_cmp", v, 32'd0);
    wb_read(c_ctrl, v); chk_eq("t31_ctrl", v, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
